// File: rtl/spi_pkg.sv
// Shared definitions for the word-oriented SPI slave: FSM state encoding
// and the all-ones pattern shifted out when no transmit word is queued.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Widest word the slave supports; narrower words take the low slice.
  localparam int MAX_DATA_W = 32;

  // MISO idles high when the transmit buffer is empty.
  localparam logic [MAX_DATA_W-1:0] IDLE_FILL = '1;

endpackage

// File: rtl/spi_shift_reg.sv
// Generic serial shift register with a parallel load.
// Load has priority over shift; q_shift is the value the register would
// take on a shift, so a caller can capture a completed word on the same edge.
module spi_shift_reg #(
  parameter int                 DATA_W    = 8,
  parameter bit                 LSB_FIRST = 1'b0,
  parameter logic [DATA_W-1:0]  RST_VAL   = '0
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load_en,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] load_val,
  input  logic              ser_in,
  output logic [DATA_W-1:0] q_shift,
  output logic              ser_out
);

  logic [DATA_W-1:0] q_reg;

  // Shift direction: MSB-first enters at bit 0 moving left,
  // LSB-first enters at the top bit moving right.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    if (LSB_FIRST) begin : g_lsb
      if (gi == DATA_W - 1) begin : g_in
        assign q_shift[gi] = ser_in;
      end else begin : g_mv
        assign q_shift[gi] = q_reg[gi + 1];
      end
    end else begin : g_msb
      if (gi == 0) begin : g_in
        assign q_shift[gi] = ser_in;
      end else begin : g_mv
        assign q_shift[gi] = q_reg[gi - 1];
      end
    end
  end

  // The bit that leaves the register first is the one presented on the wire.
  assign ser_out = LSB_FIRST ? q_reg[0] : q_reg[DATA_W-1];

  // Register update: reset, then parallel load, then shift.
  always_ff @(posedge clk) begin
    if (srst) begin
      q_reg <= RST_VAL;
    end else if (load_en) begin
      q_reg <= load_val;
    end else if (shift_en) begin
      q_reg <= q_shift;
    end
  end

endmodule

// File: rtl/spi_slave_word.sv
// SPI slave that runs entirely on sclk: receives DATA_W-bit words on MOSI,
// returns a single-entry buffered word on MISO, and reports received words
// through a pending/ack handshake with a sticky overrun flag.
module spi_slave_word
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                      sclk,
  input  logic                      rst,
  input  logic                      CS,
  input  logic                      MOSI,
  output logic                      MISO,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_pending,
  input  logic                      rx_ack,
  output logic                      overrun,
  output logic [$clog2(DATA_W)-1:0] bit_cnt
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] FILL     = IDLE_FILL[DATA_W-1:0];

  state_t            state_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic              rx_pending_reg;
  logic              overrun_reg;
  logic [DATA_W-1:0] tx_buf_reg;
  logic              tx_full_reg;

  logic              first_edge;
  logic              word_done;
  logic              tx_write;
  logic              tx_consume;
  logic              tx_load_en;
  logic [DATA_W-1:0] tx_reload_val;
  logic [DATA_W-1:0] rx_word;
  logic              tx_ser;
  logic              rx_ser_unused;
  logic [DATA_W-1:0] tx_next_unused;

  // Edge qualifiers shared by the FSM, receive and transmit paths.
  always_comb begin
    first_edge    = CS && (state_reg == IDLE);
    word_done     = CS && (bit_cnt_reg == LAST_BIT);
    tx_write      = tx_valid && !tx_full_reg;
    tx_consume    = tx_full_reg && (first_edge || word_done);
    tx_reload_val = tx_full_reg ? tx_buf_reg : FILL;
    // While deselected the transmit register keeps tracking the buffer so
    // the first bit is already on MISO when CS rises; it also reloads at
    // every word boundary so consecutive words follow with no gap.
    tx_load_en    = !CS || word_done;
  end

  // FSM: CS alone selects the state; the bit counter wraps at each word
  // and is cleared whenever CS is low, which discards partial words.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
    end else begin
      state_reg <= CS ? SHIFT : IDLE;
      if (!CS || word_done) begin
        bit_cnt_reg <= '0;
      end else begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

  // Receive status: a completing word always wins over an ack on the same
  // edge, and only a completion over an unacknowledged word is an overrun.
  always_ff @(posedge sclk) begin
    if (rst) begin
      rx_data_reg    <= '0;
      rx_pending_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else if (word_done) begin
      rx_data_reg    <= rx_word;
      rx_pending_reg <= 1'b1;
      if (rx_pending_reg && !rx_ack) begin
        overrun_reg <= 1'b1;
      end
    end else if (rx_ack) begin
      rx_pending_reg <= 1'b0;
    end
  end

  // Transmit buffer: one entry, filled by the host, emptied when the word
  // is committed to the shift register at a transfer start or word boundary.
  always_ff @(posedge sclk) begin
    if (rst) begin
      tx_buf_reg  <= '0;
      tx_full_reg <= 1'b0;
    end else if (tx_write) begin
      tx_buf_reg  <= tx_data;
      tx_full_reg <= 1'b1;
    end else if (tx_consume) begin
      tx_full_reg <= 1'b0;
    end
  end

  spi_shift_reg #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST),
    .RST_VAL   ({DATA_W{1'b0}})
  ) u_rx_shift (
    .clk      (sclk),
    .srst     (rst),
    .load_en  (1'b0),
    .shift_en (CS),
    .load_val ({DATA_W{1'b0}}),
    .ser_in   (MOSI),
    .q_shift  (rx_word),
    .ser_out  (rx_ser_unused)
  );

  spi_shift_reg #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST),
    .RST_VAL   (FILL)
  ) u_tx_shift (
    .clk      (sclk),
    .srst     (rst),
    .load_en  (tx_load_en),
    .shift_en (CS),
    .load_val (tx_reload_val),
    .ser_in   (1'b1),
    .q_shift  (tx_next_unused),
    .ser_out  (tx_ser)
  );

  // MISO is driven only while selected, straight from the shift register.
  assign MISO       = CS & tx_ser;
  assign tx_ready   = ~tx_full_reg;
  assign rx_data    = rx_data_reg;
  assign rx_pending = rx_pending_reg;
  assign overrun    = overrun_reg;
  assign bit_cnt    = bit_cnt_reg;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: an MSB-first and an LSB-first instance share
// all inputs; each scenario task drives stimulus and checks inline against
// expectations derived at the word level.
module tb_spi_slave_word;

  logic       sclk = 1'b0;
  logic       rst, CS, MOSI, tx_valid, rx_ack;
  logic [7:0] tx_data;

  logic       MISO, tx_ready, rx_pending, overrun;
  logic [7:0] rx_data;
  logic [2:0] bit_cnt;

  logic       l_miso, l_tx_ready, l_rx_pending, l_overrun;
  logic [7:0] l_rx_data;
  logic [2:0] l_bit_cnt;

  int errors = 0;
  int checks = 0;

  always #5 sclk = ~sclk;

  spi_slave_word #(.DATA_W(8), .LSB_FIRST(1'b0)) dut (
    .sclk(sclk), .rst(rst), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_pending(rx_pending), .rx_ack(rx_ack),
    .overrun(overrun), .bit_cnt(bit_cnt)
  );

  spi_slave_word #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_lsb (
    .sclk(sclk), .rst(rst), .CS(CS), .MOSI(MOSI), .MISO(l_miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(l_tx_ready),
    .rx_data(l_rx_data), .rx_pending(l_rx_pending), .rx_ack(rx_ack),
    .overrun(l_overrun), .bit_cnt(l_bit_cnt)
  );

  // One rising edge, returning at the following falling edge (sample point).
  task automatic tick();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic do_reset();
    rst = 1'b1; CS = 1'b0; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Queue a word for transmit while deselected, then give it one idle edge
  // so it reaches the shift register before CS rises.
  task automatic idle_write(input logic [7:0] v);
    CS = 1'b0; tx_data = v; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
  endtask

  // Clock one full word with CS held high; CS is left high afterwards so
  // calls can be chained back to back. Records MISO as seen by both
  // instances (reassembled in their own bit order), bit_cnt after each
  // edge, rx_pending rises and tx_ready after the first edge.
  task automatic xfer(input logic [7:0] w, input bit lsb_order, input bit ack_last,
                      input int tx_at, input logic [7:0] tx_word,
                      output logic [7:0] miso_m, output logic [7:0] miso_l,
                      output logic [23:0] cseq, output int rises, output logic rdy1);
    logic prev;
    rises = 0; miso_m = '0; miso_l = '0; cseq = '0; rdy1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      CS       = 1'b1;
      MOSI     = lsb_order ? w[i] : w[7-i];
      rx_ack   = ack_last && (i == 7);
      tx_valid = (i == tx_at);
      tx_data  = tx_word;
      #1;
      miso_m[7-i] = MISO;
      miso_l[i]   = l_miso;
      prev        = rx_pending;
      tick();
      rx_ack   = 1'b0;
      tx_valid = 1'b0;
      cseq[3*i +: 3] = bit_cnt;
      if (!prev && rx_pending) rises++;
      if (i == 0) rdy1 = tx_ready;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; CS = 1'b0; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ack = 1'b0;
    tick(); tick();
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (rx_pending !== 1'b0) begin errors++; $display("FAIL reset_rx_pending: got %b want 0", rx_pending); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso_cs0: got %b want 0", MISO); end
    // Reset must dominate CS, MOSI and a tx write.
    CS = 1'b1; MOSI = 1'b1; tx_valid = 1'b1; tx_data = 8'h77;
    tick();
    checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL reset_miso_cs1: got %b want 1", MISO); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt_cs1: got %0d want 0", bit_cnt); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_wr: got %b want 1", tx_ready); end
    CS = 1'b0; MOSI = 1'b0; tx_valid = 1'b0; rst = 1'b0;
    tick();
    $display("reset done");
  endtask

  task automatic test_basic();
    logic [7:0] mm, ml; logic [23:0] cseq, exp_cs; int rs; logic rdy;
    for (int i = 0; i < 8; i++) exp_cs[3*i +: 3] = 3'((i + 1) % 8);
    CS = 1'b0; tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_full: got %b want 0", tx_ready); end
    tick();
    xfer(8'h3C, 1'b0, 1'b0, -1, 8'h00, mm, ml, cseq, rs, rdy);
    $display("basic: mosi=3c miso=%02h rx=%02h", mm, rx_data);
    checks++; if (mm !== 8'hA5) begin errors++; $display("FAIL basic_miso: got %h want a5", mm); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_ready_edge1: got %b want 1", rdy); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL basic_rx_data: got %h want 3c", rx_data); end
    checks++; if (rx_pending !== 1'b1) begin errors++; $display("FAIL basic_pending: got %b want 1", rx_pending); end
    checks++; if (cseq !== exp_cs) begin errors++; $display("FAIL basic_bit_cnt_seq: got %h want %h", cseq, exp_cs); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b want 0", overrun); end
    CS = 1'b0; rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    checks++; if (rx_pending !== 1'b0) begin errors++; $display("FAIL basic_ack: got %b want 0", rx_pending); end
  endtask

  task automatic test_idle_fill();
    logic [7:0] w, mm, ml; logic [23:0] cseq; int rs; logic rdy;
    w = 8'($urandom);
    xfer(w, 1'b0, 1'b0, -1, 8'h00, mm, ml, cseq, rs, rdy);
    $display("idle_fill: mosi=%02h miso=%02h rx=%02h", w, mm, rx_data);
    checks++; if (mm !== 8'hFF) begin errors++; $display("FAIL fill_miso: got %h want ff", mm); end
    checks++; if (rx_data !== w) begin errors++; $display("FAIL fill_rx_data: got %h want %h", rx_data, w); end
    CS = 1'b0;
    #1;
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL fill_miso_cs0: got %b want 0", MISO); end
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] a, mm, ml; logic [23:0] cseq; int rs; logic rdy;
    do_reset();
    xfer(8'h11, 1'b0, 1'b0, -1, 8'h00, mm, ml, cseq, rs, rdy);
    xfer(8'h22, 1'b0, 1'b0, -1, 8'h00, mm, ml, cseq, rs, rdy);
    $display("overrun: words 11,22 rx=%02h ovr=%b", rx_data, overrun);
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ovr_rx_data: got %h want 22", rx_data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    CS = 1'b0; rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    checks++; if (rx_pending !== 1'b0) begin errors++; $display("FAIL ovr_ack: got %b want 0", rx_pending); end
    xfer(8'h33, 1'b0, 1'b0, -1, 8'h00, mm, ml, cseq, rs, rdy);
    $display("overrun: word 33 rx=%02h ovr=%b pend=%b", rx_data, overrun, rx_pending);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    checks++; if (rx_pending !== 1'b1) begin errors++; $display("FAIL ovr_pending33: got %b want 1", rx_pending); end
    checks++; if (rx_data !== 8'h33) begin errors++; $display("FAIL ovr_rx33: got %h want 33", rx_data); end
    // Ack on the completion edge: the new word wins, no overrun.
    do_reset();
    a = 8'($urandom);
    xfer(a, 1'b0, 1'b0, -1, 8'h00, mm, ml, cseq, rs, rdy);
    xfer(~a, 1'b0, 1'b1, -1, 8'h00, mm, ml, cseq, rs, rdy);
    $display("ack_collision: words %02h,%02h rx=%02h", a, ~a, rx_data);
    checks++; if (rx_pending !== 1'b1) begin errors++; $display("FAIL coll_pending: got %b want 1", rx_pending); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coll_overrun: got %b want 0", overrun); end
    checks++; if (rx_data !== ~a) begin errors++; $display("FAIL coll_rx_data: got %h want %h", rx_data, ~a); end
    CS = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    logic [7:0] mm, ml; logic [23:0] cseq; int rs; logic rdy;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      CS = 1'b1; MOSI = 1'($urandom);
      tick();
    end
    checks++; if (bit_cnt !== 3'd3) begin errors++; $display("FAIL abort_cnt3: got %0d want 3", bit_cnt); end
    CS = 1'b0;
    tick();
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL abort_cnt0: got %0d want 0", bit_cnt); end
    checks++; if (rx_pending !== 1'b0) begin errors++; $display("FAIL abort_pending: got %b want 0", rx_pending); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL abort_rx_data: got %h want 00", rx_data); end
    xfer(8'h5A, 1'b0, 1'b0, -1, 8'h00, mm, ml, cseq, rs, rdy);
    $display("abort: then word 5a rx=%02h rises=%0d", rx_data, rs);
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL abort_rx5a: got %h want 5a", rx_data); end
    checks++; if (rs !== 1) begin errors++; $display("FAIL abort_rises: got %0d want 1", rs); end
    CS = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] mm, ml; logic [23:0] cseq; int rs; logic rdy;
    do_reset();
    xfer(8'h01, 1'b0, 1'b0, -1, 8'h00, mm, ml, cseq, rs, rdy);
    xfer(8'h02, 1'b0, 1'b0, -1, 8'h00, mm, ml, cseq, rs, rdy);
    idle_write(8'h96);
    for (int i = 0; i < 5; i++) begin
      CS = 1'b1; MOSI = 1'($urandom);
      tick();
    end
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h44;
    tick();
    tx_valid = 1'b0;
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", bit_cnt); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rmid_rx_data: got %h want 00", rx_data); end
    checks++; if (rx_pending !== 1'b0) begin errors++; $display("FAIL rmid_pending: got %b want 0", rx_pending); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun: got %b want 0", overrun); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", tx_ready); end
    checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL rmid_miso: got %b want 1", MISO); end
    rst = 1'b0; CS = 1'b0;
    tick();
    xfer(8'hC3, 1'b0, 1'b0, -1, 8'h00, mm, ml, cseq, rs, rdy);
    $display("reset_mid: then word c3 rx=%02h miso=%02h", rx_data, mm);
    checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL rmid_rxc3: got %h want c3", rx_data); end
    checks++; if (rx_pending !== 1'b1) begin errors++; $display("FAIL rmid_pend_c3: got %b want 1", rx_pending); end
    checks++; if (mm !== 8'hFF) begin errors++; $display("FAIL rmid_miso_fill: got %h want ff", mm); end
    CS = 1'b0;
    tick();
  endtask

  task automatic test_lsb_first();
    logic [7:0] mm, ml; logic [23:0] cseq; int rs; logic rdy;
    do_reset();
    idle_write(8'h80);
    // Wire bits 1,0,0,0,0,0,0,0 in time order.
    xfer(8'h01, 1'b1, 1'b0, -1, 8'h00, mm, ml, cseq, rs, rdy);
    $display("lsb_first: lsb rx=%02h miso=%02h | msb rx=%02h miso=%02h", l_rx_data, ml, rx_data, mm);
    checks++; if (l_rx_data !== 8'h01) begin errors++; $display("FAIL lsb_rx_data: got %h want 01", l_rx_data); end
    checks++; if (ml !== 8'h80) begin errors++; $display("FAIL lsb_miso: got %h want 80", ml); end
    checks++; if (l_rx_pending !== 1'b1) begin errors++; $display("FAIL lsb_pending: got %b want 1", l_rx_pending); end
    checks++; if (l_bit_cnt !== 3'd0) begin errors++; $display("FAIL lsb_cnt: got %0d want 0", l_bit_cnt); end
    checks++; if (l_overrun !== 1'b0) begin errors++; $display("FAIL lsb_overrun: got %b want 0", l_overrun); end
    checks++; if (l_tx_ready !== 1'b1) begin errors++; $display("FAIL lsb_ready: got %b want 1", l_tx_ready); end
    checks++; if (rx_data !== 8'h80) begin errors++; $display("FAIL msb_same_stream: got %h want 80", rx_data); end
    checks++; if (mm !== 8'h80) begin errors++; $display("FAIL msb_miso80: got %h want 80", mm); end
    CS = 1'b0;
    tick();
  endtask

  // Random bursts of 1..3 words with random idle writes, idle acks,
  // completion-edge acks, mid-word tx writes and aborted partial words.
  task automatic test_random();
    logic [7:0] exp_rx, exp_buf, exp_miso, w, tw, mm, ml;
    logic [23:0] cseq; int rs, nw, ta, k_bits; logic rdy;
    bit exp_pend, exp_ovr, exp_full, ack;
    do_reset();
    exp_rx = 8'h00; exp_buf = 8'h00; exp_pend = 1'b0; exp_ovr = 1'b0; exp_full = 1'b0;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        tw = 8'($urandom);
        idle_write(tw);
        if (!exp_full) begin exp_full = 1'b1; exp_buf = tw; end
      end
      if ($urandom_range(0, 1) == 1) begin
        CS = 1'b0; rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        exp_pend = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        k_bits = int'($urandom_range(1, 7));
        for (int b = 0; b < k_bits; b++) begin
          CS = 1'b1; MOSI = 1'($urandom);
          tick();
        end
        CS = 1'b0;
        tick();
        exp_full = 1'b0;
        checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL rand_abort_cnt it%0d: got %0d want 0", it, bit_cnt); end
        checks++; if (rx_pending !== exp_pend) begin errors++; $display("FAIL rand_abort_pend it%0d: got %b want %b", it, rx_pending, exp_pend); end
      end
      nw = int'($urandom_range(1, 3));
      for (int k = 0; k < nw; k++) begin
        w = 8'($urandom);
        tw = 8'($urandom);
        exp_miso = exp_full ? exp_buf : 8'hFF;
        exp_full = 1'b0;
        ta = -1;
        if (k < nw - 1 && $urandom_range(0, 1) == 1) ta = int'($urandom_range(1, 6));
        ack = ($urandom_range(0, 3) == 0);
        xfer(w, 1'b0, ack, ta, tw, mm, ml, cseq, rs, rdy);
        if (ta >= 0) begin exp_full = 1'b1; exp_buf = tw; end
        if (exp_pend && !ack) exp_ovr = 1'b1;
        exp_rx = w;
        exp_pend = 1'b1;
        $display("xfer %0d.%0d mosi=%02h miso=%02h rx=%02h pend=%b ovr=%b", it, k, w, mm, rx_data, rx_pending, overrun);
        checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL rand_rx_data %0d.%0d: got %h want %h", it, k, rx_data, exp_rx); end
        checks++; if (rx_pending !== exp_pend) begin errors++; $display("FAIL rand_pending %0d.%0d: got %b want %b", it, k, rx_pending, exp_pend); end
        checks++; if (overrun !== exp_ovr) begin errors++; $display("FAIL rand_overrun %0d.%0d: got %b want %b", it, k, overrun, exp_ovr); end
        checks++; if (mm !== exp_miso) begin errors++; $display("FAIL rand_miso %0d.%0d: got %h want %h", it, k, mm, exp_miso); end
      end
      CS = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_fill();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_lsb_first();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_word.md
SPI_SLAVE_WORD -- requirements
Module: spi_slave_word

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning bits per SPI word (legal range 4..32).
REQ-002 The block SHALL have parameter LSB_FIRST, default 0: 0 = MSB-first on MOSI and MISO, 1 = LSB-first.
REQ-003 The block SHALL have port sclk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port CS, input, 1 bit: chip select, active-high, sampled on sclk.
REQ-006 The block SHALL have port MOSI, input, 1 bit: serial data in.
REQ-007 The block SHALL have port MISO, output, 1 bit: serial data out.
REQ-008 The block SHALL have port tx_data, input, DATA_W bits: word to transmit.
REQ-009 The block SHALL have port tx_valid, input, 1 bit: tx_data offered.
REQ-010 The block SHALL have port tx_ready, output, 1 bit: tx buffer empty, write accepted.
REQ-011 The block SHALL have port rx_data, output, DATA_W bits: last complete received word.
REQ-012 The block SHALL have port rx_pending, output, 1 bit: unread word in rx_data.
REQ-013 The block SHALL have port rx_ack, input, 1 bit: consumer has read rx_data.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag, word completed while rx_pending=1.
REQ-015 The block SHALL have port bit_cnt, output, clog2(DATA_W) bits: bits received in the current word.

Function
REQ-016 The state machine SHALL have states IDLE (CS=0) and SHIFT (CS=1); every edge with CS=1 goes to SHIFT, every edge with CS=0 goes to IDLE with bit_cnt=0.
REQ-017 On each edge with CS=1, MOSI SHALL shift into rx_shift (MSB-first: into bit 0, shifting left; LSB_FIRST=1: into bit DATA_W-1, shifting right) and bit_cnt SHALL increment.
REQ-018 On the edge where bit_cnt=DATA_W-1 and CS=1: rx_data <= completed word; rx_pending <= 1; bit_cnt <= 0; the next word starts on the following edge with no gap.
REQ-019 rx_ack=1 SHALL clear rx_pending next edge; completion on the same edge wins (rx_pending stays 1, overrun not set).
REQ-020 Completion while rx_pending=1 and rx_ack=0 SHALL overwrite rx_data and set overrun; overrun clears only on rst.
REQ-021 tx_ready SHALL be ~tx_full; tx_valid&tx_ready SHALL load tx_buf and set tx_full next edge.
REQ-022 In IDLE, tx_shift SHALL be loaded each edge with tx_buf if tx_full, else all-ones, without consuming tx_buf.
REQ-023 On the first SHIFT edge of a transfer (state IDLE, CS=1), tx_full SHALL clear if set, and tx_shift SHALL shift by one.
REQ-024 On each word-completion edge, tx_shift SHALL reload from tx_buf (tx_full cleared) or all-ones if empty.
REQ-025 MISO SHALL be CS ? tx_shift[DATA_W-1] (tx_shift[0] if LSB_FIRST) : 0, combinational from registers and CS.
REQ-026 CS dropping mid-word SHALL discard the partial word: no rx_data or rx_pending change, and bit_cnt=0 next edge.

Reset
REQ-027 rst=1 at any edge, including mid-word, SHALL force: state IDLE, bit_cnt 0, rx_shift 0, rx_data 0, rx_pending 0, overrun 0, tx_full 0 (tx_ready 1), tx_shift all-ones; rst takes precedence over all other inputs.
REQ-028 MISO SHALL read 0 during reset only if CS=0; with CS=1 it SHALL read 1.

Structure
REQ-029 A shared package spi_pkg SHALL hold the state typedef (IDLE, SHIFT) and the all-ones idle-fill constant.
REQ-030 The rx and tx shift registers SHALL be built from one sub-module spi_shift_reg, parametrised by DATA_W and LSB_FIRST with load/shift enables.

Verification
REQ-031 With DATA_W=8 and tx 0xA5 preloaded: CS=1 and 8 MOSI bits of 0x3C MSB-first SHALL give rx_data=0x3C and rx_pending=1 after edge 8, MISO sequence 1,0,1,0,0,1,0,1, and tx_ready=1 after edge 1.
REQ-032 Two back-to-back words 0x11 then 0x22 with no rx_ack SHALL give rx_data=0x22 and overrun=1; sending 0x33 after rx_ack SHALL keep overrun=1 and set rx_pending=1.
REQ-033 With no tx write, an 8-bit transfer SHALL drive MISO=1 for all 8 bits; CS=0 SHALL drive MISO=0.
REQ-034 CS=1 for 3 bits, then CS=0 for 1 cycle, then a full 0x5A word SHALL give rx_data=0x5A with exactly one rx_pending rise.
REQ-035 rst pulsed after 5 bits SHALL force all REQ-027 values; a following 0xC3 word SHALL be received correctly.
REQ-036 With LSB_FIRST=1, MOSI bits 1,0,0,0,0,0,0,0 SHALL give rx_data=0x01, and tx 0x80 SHALL give MISO 0,0,0,0,0,0,0,1.
